// File: rtl/bf8_arb_pkg.sv
// rtl/bf8_arb_pkg.sv - shared types and widths for the BrainForge8 bus arbiter
package bf8_arb_pkg;

    typedef enum logic [2:0] {
        CPU_OWN  = 3'd0,
        DRAIN    = 3'd1,
        TURN_IN  = 3'd2,
        DMA_OWN  = 3'd3,
        TURN_OUT = 3'd4
    } arb_state_t;

    localparam int TURN_W     = 4;
    localparam int STAT_CYC_W = 16;
    localparam int STAT_GNT_W = 8;

    // The turnaround counter runs down to zero, so it is loaded with cycles-1.
    function automatic logic [TURN_W-1:0] turn_load(input int unsigned cycles);
        return TURN_W'(cycles - 1);
    endfunction

endpackage

// File: rtl/arb_watchdog.sv
// rtl/arb_watchdog.sv - saturating DMA tenure counter with a single-cycle limit pulse
module arb_watchdog #(
    parameter int unsigned LIMIT = 1024,
    parameter int unsigned W     = 11
) (
    input  logic CLK,
    input  logic RST,
    input  logic clr,
    input  logic en,
    output logic pulse
);

    localparam logic [W-1:0] LIM = W'(LIMIT);

    logic [W-1:0] cnt;

    // Pulse fires on the same edge the count lands on LIMIT; saturation then keeps it quiet.
    always_ff @(posedge CLK) begin
        if (RST || clr) begin
            cnt   <= '0;
            pulse <= 1'b0;
        end else if (en && (LIMIT != 0) && (cnt != LIM)) begin
            cnt   <= cnt + W'(1);
            pulse <= (cnt == LIM - W'(1));
        end else begin
            pulse <= 1'b0;
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - BrainForge8 CPU/DMA bus owner with turnaround and tenure watchdog
// Optional grant/cycle statistics are built when ARB_STATS_EN is defined.
module bus_arbiter
    import bf8_arb_pkg::*;
#(
    parameter int unsigned TURN_CYCLES = 1,
    parameter int unsigned WDT_CYCLES  = 1024,
    parameter int unsigned WDT_W       = 11
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  BR,
    input  logic                  CPU_SYNC,
    output logic                  BA,
    output logic                  CPU_HALT,
    output logic                  CPU_BE,
    output logic                  OWNER,
    output logic                  TRIG_BUSW,
    input  logic                  STAT_CLR,
    output logic [STAT_CYC_W-1:0] STAT_CYC,
    output logic [STAT_GNT_W-1:0] STAT_GNT
);

    localparam logic [TURN_W-1:0] TURN_LOAD = turn_load(TURN_CYCLES);

    arb_state_t        state;
    logic [TURN_W-1:0] turn_cnt;
    logic              ba_q;
    logic              halt_q;
    logic              be_q;
    logic              owner_q;
    logic              in_dma;
    logic              grant;

    assign in_dma = (state == DMA_OWN);
    assign grant  = (state == TURN_IN) && BR && (turn_cnt == '0);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= CPU_OWN;
            turn_cnt <= '0;
            ba_q     <= 1'b0;
            halt_q   <= 1'b0;
            be_q     <= 1'b1;
            owner_q  <= 1'b0;
        end else begin
            case (state)
                CPU_OWN: begin
                    ba_q    <= 1'b0;
                    be_q    <= 1'b1;
                    owner_q <= 1'b0;
                    if (BR) begin
                        state  <= DRAIN;
                        halt_q <= 1'b1;
                    end else begin
                        halt_q <= 1'b0;
                    end
                end
                // A withdrawn request wins over CPU_SYNC arriving in the same cycle.
                DRAIN: begin
                    if (!BR) begin
                        state  <= CPU_OWN;
                        halt_q <= 1'b0;
                    end else if (CPU_SYNC) begin
                        state    <= TURN_IN;
                        be_q     <= 1'b0;
                        turn_cnt <= TURN_LOAD;
                    end
                end
                TURN_IN: begin
                    if (!BR) begin
                        state    <= TURN_OUT;
                        turn_cnt <= TURN_LOAD;
                    end else if (turn_cnt == '0) begin
                        state   <= DMA_OWN;
                        ba_q    <= 1'b1;
                        owner_q <= 1'b1;
                    end else begin
                        turn_cnt <= turn_cnt - TURN_W'(1);
                    end
                end
                DMA_OWN: begin
                    if (!BR) begin
                        state    <= TURN_OUT;
                        ba_q     <= 1'b0;
                        owner_q  <= 1'b0;
                        turn_cnt <= TURN_LOAD;
                    end
                end
                // BR is not looked at here; a new request waits until CPU_OWN.
                TURN_OUT: begin
                    if (turn_cnt == '0) begin
                        state  <= CPU_OWN;
                        halt_q <= 1'b0;
                        be_q   <= 1'b1;
                    end else begin
                        turn_cnt <= turn_cnt - TURN_W'(1);
                    end
                end
                default: begin
                    state    <= CPU_OWN;
                    turn_cnt <= '0;
                    ba_q     <= 1'b0;
                    halt_q   <= 1'b0;
                    be_q     <= 1'b1;
                    owner_q  <= 1'b0;
                end
            endcase
        end
    end

    assign BA       = ba_q;
    assign CPU_HALT = halt_q;
    assign CPU_BE   = be_q;
    assign OWNER    = owner_q;

    // The watchdog only reports; the DMA may be mid-write, so BA is never pulled.
    arb_watchdog #(
        .LIMIT (WDT_CYCLES),
        .W     (WDT_W)
    ) u_wdt (
        .CLK   (CLK),
        .RST   (RST),
        .clr   (!in_dma),
        .en    (in_dma),
        .pulse (TRIG_BUSW)
    );

`ifdef ARB_STATS_EN
    logic [STAT_CYC_W-1:0] stat_cyc_q;
    logic [STAT_GNT_W-1:0] stat_gnt_q;

    always_ff @(posedge CLK) begin
        if (RST || STAT_CLR) begin
            stat_cyc_q <= '0;
            stat_gnt_q <= '0;
        end else begin
            if (in_dma && (stat_cyc_q != '1))
                stat_cyc_q <= stat_cyc_q + STAT_CYC_W'(1);
            if (grant && (stat_gnt_q != '1))
                stat_gnt_q <= stat_gnt_q + STAT_GNT_W'(1);
        end
    end

    assign STAT_CYC = stat_cyc_q;
    assign STAT_GNT = stat_gnt_q;
`else
    logic unused_stats;
    assign unused_stats = STAT_CLR ^ grant;
    assign STAT_CYC     = '0;
    assign STAT_GNT     = '0;
`endif

endmodule
